wb_regfile: RTL and testbench

- Write-back stage plus architectural register file for the 5-stage MIPS pipeline.
- Consumes the MEM/WB pipeline register outputs, selects the write-back value, and commits it to a 32-entry register file.
- Provides two combinational read ports to ID, with write-through bypass so a same-cycle write is visible to decode.
- Exposes the selected write-back value for EX forwarding and a retired-write counter for debug.

---
 rtl/wb_regfile.sv | 66 ++++++
 tb/tb_wb_regfile.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
// Write-back stage and 32-entry architectural register file for the 5-stage MIPS pipeline.
// Two combinational read ports with optional write-through bypass; r0 is hardwired to zero.
module wb_regfile #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter bit          BYPASS = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_reg_write,
  input  logic              wb_mem_to_reg,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_mem_read_data,
  input  logic [DATA_W-1:0] wb_alu_result,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_we_eff,
  output logic [31:0]       retire_count
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [Depth];
  logic [31:0]       retire_q;

  assign wb_data      = wb_mem_to_reg ? wb_mem_read_data : wb_alu_result;
  assign wb_we_eff    = wb_reg_write && (wb_rd != '0);
  assign retire_count = retire_q;

  // wb_we_eff already excludes index 0, so entry 0 is never written.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < Depth; i++) begin
        regs_q[i] <= '0;
      end
      retire_q <= '0;
    end else if (wb_we_eff) begin
      regs_q[wb_rd] <= wb_data;
      retire_q      <= retire_q + 32'd1;
    end
  end

  always_comb begin
    rs_data = regs_q[rs_addr];
    if (BYPASS && wb_we_eff && (wb_rd == rs_addr)) begin
      rs_data = wb_data;
    end
    if (rs_addr == '0) begin
      rs_data = '0;
    end
  end

  always_comb begin
    rt_data = regs_q[rt_addr];
    if (BYPASS && wb_we_eff && (wb_rd == rt_addr)) begin
      rt_data = wb_data;
    end
    if (rt_addr == '0) begin
      rt_data = '0;
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: bypass and non-bypass instances share stimulus and are compared
// every cycle against an array-based reference model, plus directed literal checks.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_reg_write;
  logic        wb_mem_to_reg;
  logic [4:0]  wb_rd;
  logic [31:0] wb_mem_read_data;
  logic [31:0] wb_alu_result;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;

  logic [31:0] rs_b, rt_b, wbd_b, cnt_b;
  logic        we_b;
  logic [31:0] rs_n, rt_n, wbd_n, cnt_n;
  logic        we_n;

  int checks   = 0;
  int failures = 0;

  logic [31:0] model_mem [32];
  logic [31:0] model_cnt;

  always #5 clk = ~clk;

  wb_regfile #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b1)) dut_b (
    .clk(clk), .reset(reset), .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg),
    .wb_rd(wb_rd), .wb_mem_read_data(wb_mem_read_data), .wb_alu_result(wb_alu_result),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_b), .rt_data(rt_b),
    .wb_data(wbd_b), .wb_we_eff(we_b), .retire_count(cnt_b)
  );

  wb_regfile #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b0)) dut_n (
    .clk(clk), .reset(reset), .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg),
    .wb_rd(wb_rd), .wb_mem_read_data(wb_mem_read_data), .wb_alu_result(wb_alu_result),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_n), .rt_data(rt_n),
    .wb_data(wbd_n), .wb_we_eff(we_n), .retire_count(cnt_n)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_wbdata();
    return wb_mem_to_reg ? wb_mem_read_data : wb_alu_result;
  endfunction

  function automatic logic m_we();
    return wb_reg_write && (wb_rd != 5'd0);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a, input bit bypass);
    if (a == 5'd0) return 32'd0;
    if (bypass && m_we() && (wb_rd == a)) return m_wbdata();
    return model_mem[a];
  endfunction

  // Reference model state update.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) model_mem[i] = 32'd0;
      model_cnt = 32'd0;
    end else if (m_we()) begin
      model_mem[wb_rd] = m_wbdata();
      model_cnt = model_cnt + 32'd1;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (reset !== 1'bx) begin
      chk("rs_bypass",  rs_b,  m_read(rs_addr, 1'b1));
      chk("rt_bypass",  rt_b,  m_read(rt_addr, 1'b1));
      chk("rs_nobyp",   rs_n,  m_read(rs_addr, 1'b0));
      chk("rt_nobyp",   rt_n,  m_read(rt_addr, 1'b0));
      chk("wb_data",    wbd_b, m_wbdata());
      chk("wb_data_n",  wbd_n, m_wbdata());
      chk("wb_we_eff",  {31'd0, we_b}, {31'd0, m_we()});
      chk("retire_b",   cnt_b, model_cnt);
      chk("retire_n",   cnt_n, model_cnt);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic to_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    wb_reg_write = 1'b0;
    wb_mem_to_reg = 1'b0;
    wb_rd = 5'd0;
    wb_mem_read_data = 32'd0;
    wb_alu_result = 32'd0;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    rs_addr = 5'd0;
    rt_addr = 5'd0;
    cyc();
    cyc();
    reset = 1'b0;

    // All reads zero after reset.
    for (int a = 0; a < 32; a++) begin
      rs_addr = 5'(a);
      rt_addr = 5'(31 - a);
      #1;
      chk("reset_rs", rs_b, 32'd0);
      chk("reset_rt", rt_n, 32'd0);
    end
    chk("reset_cnt", cnt_b, 32'd0);
    cyc();

    // ALU write to r5.
    wb_reg_write = 1'b1; wb_rd = 5'd5; wb_alu_result = 32'h1234_5678;
    cyc();
    idle();
    rs_addr = 5'd5;
    to_neg();
    chk("r5_lit", rs_b, 32'h1234_5678);
    chk("r5_lit_n", rs_n, 32'h1234_5678);
    chk("cnt1_lit", cnt_b, 32'd1);
    cyc();

    // Load write to r9 with same-cycle read.
    wb_reg_write = 1'b1; wb_mem_to_reg = 1'b1; wb_rd = 5'd9;
    wb_mem_read_data = 32'hDEAD_BEEF; wb_alu_result = 32'h1;
    rs_addr = 5'd9; rt_addr = 5'd9;
    to_neg();
    chk("byp_rs_lit", rs_b, 32'hDEAD_BEEF);
    chk("byp_rt_lit", rt_b, 32'hDEAD_BEEF);
    chk("wbd_lit", wbd_b, 32'hDEAD_BEEF);
    chk("nobyp_rs_lit", rs_n, 32'd0);
    chk("nobyp_rt_lit", rt_n, 32'd0);
    cyc();
    idle();
    to_neg();
    chk("r9_after_n", rs_n, 32'hDEAD_BEEF);
    cyc();

    // Write to r0 is discarded.
    wb_reg_write = 1'b1; wb_rd = 5'd0; wb_alu_result = 32'hFFFF_FFFF;
    rs_addr = 5'd0;
    to_neg();
    chk("r0_we_lit", {31'd0, we_b}, 32'd0);
    chk("r0_rd_lit", rs_b, 32'd0);
    cyc();
    idle();
    to_neg();
    chk("r0_cnt_lit", cnt_b, 32'd2);
    cyc();

    // Reset coincident with a write edge.
    wb_reg_write = 1'b1; wb_rd = 5'd3; wb_alu_result = 32'hAAAA_0000;
    cyc();
    wb_alu_result = 32'h0000_5555;
    rs_addr = 5'd3;
    @(negedge clk);
    #4;
    reset = 1'b1;
    cyc();
    idle();
    to_neg();
    chk("rst_r3_lit", rs_b, 32'd0);
    chk("rst_cnt_lit", cnt_b, 32'd0);
    cyc();
    reset = 1'b0;
    wb_reg_write = 1'b1; wb_rd = 5'd7; wb_alu_result = 32'h0000_0077;
    cyc();
    idle();
    to_neg();
    chk("post_rst_cnt_lit", cnt_b, 32'd1);
    cyc();

    // Counter wrap via back-door preload.
    #1;
    dut_b.retire_q = 32'hFFFF_FFFF;
    dut_n.retire_q = 32'hFFFF_FFFF;
    model_cnt = 32'hFFFF_FFFF;
    wb_reg_write = 1'b1; wb_rd = 5'd12; wb_alu_result = 32'hCAFE_F00D;
    cyc();
    idle();
    rs_addr = 5'd12;
    to_neg();
    chk("wrap_cnt_lit", cnt_b, 32'd0);
    chk("wrap_r12_lit", rs_b, 32'hCAFE_F00D);
    cyc();

    // Randomised traffic, with occasional reset pulses.
    for (int i = 0; i < 600; i++) begin
      wb_reg_write     = ($urandom_range(0, 3) != 0);
      wb_mem_to_reg    = 1'($urandom);
      wb_rd            = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      wb_mem_read_data = $urandom;
      wb_alu_result    = $urandom;
      rs_addr          = ($urandom_range(0, 3) == 0) ? wb_rd : 5'($urandom);
      rt_addr          = ($urandom_range(0, 3) == 0) ? wb_rd : 5'($urandom);
      reset            = ($urandom_range(0, 149) == 0);
      cyc();
    end
    reset = 1'b0;
    idle();
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
